mul_mac_seq: RTL and testbench
==============================

# mul_mac_seq

Parametrised sequential multiply-accumulate unit for the affine-transform datapath, succeeding the single-mode radix-2 shift-add multiplier. It processes BPC multiplier bits per cycle and supports both signed and unsigned operands. An internal accumulator with guard bits can accumulate products across operations. It also produces a rounded, saturated Q-format result, so coefficient × coordinate terms can be summed without an external adder.

## Interface
- WIDTH, 16: operand width; must be a multiple of BPC.
- BPC, 2: multiplier bits retired per cycle (1, 2, 4 or 8); N = WIDTH/BPC iteration cycles.
- FRAC, 8: fractional bits of the Q-format output; 1 ≤ FRAC < WIDTH.
- GUARD, 4: accumulator guard bits; ACC_W = 2*WIDTH+GUARD.
- clk_i  input  1  clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start_i  input  1  request an operation; accepted only when busy_o=0.
- signed_i  input  1  1 = two's-complement operands, 0 = unsigned; sampled at accept.
- acc_en_i  input  1  1 = add product to accumulator, 0 = overwrite; sampled at accept.
- clr_i  input  1  clear accumulator; honoured only when busy_o=0.
- a_i, b_i  input  WIDTH  operands, sampled at accept.
- result_o  output  ACC_W  full accumulator value (signed or unsigned per last op).
- q_o  output  WIDTH  rounded, saturated (result_o >> FRAC).
- sat_o  output  1  q_o was clamped in the last completed op.
- done_o  output  1  one-cycle pulse when result_o/q_o update.
- busy_o  output  1  operation in progress.

## Operation
- States: IDLE, RUN. Reset → IDLE; all outputs and the accumulator are 0.
- Accept (IDLE, start_i=1):
  - Latch mode and acc_en.
  - Latch magnitudes |a|, |b| as WIDTH-bit unsigned; the most-negative value maps to 2^(WIDTH-1) without overflow.
  - Latch sign = a[MSB]^b[MSB] in signed mode; sign = 0 in unsigned mode.
  - Clear partial product and go to RUN.
- RUN: each cycle, add |a| × (next BPC bits of |b|), shifted by BPC×iteration, into the partial product. The multiplier shifts right by BPC and the counter increments.
- On the final (Nth) RUN cycle:
  - Product P = sign ? −partial : partial, sign-extended (signed mode) or zero-extended to ACC_W.
  - acc ← (acc_en ? acc : 0) + P, wrapping modulo 2^ACC_W.
  - Update result_o, q_o and sat_o; pulse done_o; return to IDLE.
- q_o computation:
  - Rounding: t = (acc + 2^(FRAC−1)) >>> FRAC (round half up); arithmetic shift in signed mode, logical in unsigned.
  - Saturation: clamp to [−2^(WIDTH−1), 2^(WIDTH−1)−1] in signed mode, [0, 2^WIDTH−1] in unsigned. sat_o = 1 iff clamped.
- clr_i in IDLE: accumulator, result_o, q_o and sat_o ← 0 next edge.
  - With start_i in the same cycle, the clear is applied and the op runs with acc treated as 0.
  - clr_i while busy is ignored.
- start_i while busy is ignored; no queuing.
- Reset asserted mid-RUN aborts immediately; no done_o is produced.

## Timing
- Accept at edge k: busy_o=1 after k. done_o=1 and outputs valid after edge k+N. busy_o=0 in the same cycle as done_o.
- Start-to-done latency is N cycles (8 for defaults). The earliest next accept is the edge after done_o (throughput N+1).
- result_o, q_o and sat_o hold between completions and remain stable while busy.
- Operand/mode inputs may change freely after the accept edge.

## Structure
- Package mul_mac_pkg: state enum (IDLE, RUN), a function computing ACC_W, and the rounding/saturation bound helpers.
- Sub-module mul_q_round (combinational): ACC_W accumulator + mode → q_o, sat_o. Shared with the future affine output stage.
- Top contains the FSM, counter ($clog2(N+1) bits), BPC-wide partial-product adder and accumulator.

## Test plan
(WIDTH=16, BPC=2, FRAC=8, GUARD=4 unless stated)
- Signed 3 × −5, acc_en=0 → done_o exactly 8 cycles after accept; result_o = −15, q_o = 0, sat_o = 0.
- Signed −32768 × −32768 → result_o = 0x4000_0000; q_o = 0x7FFF, sat_o = 1. Signed −32768 × 1 → result_o = −32768, q_o = 0xFF80.
- Unsigned 0xFFFF × 0xFFFF → result_o = 0xFFFE0001, q_o = 0xFFFF, sat_o = 1.
- Accumulate: 0x0100 × 0x0200 (acc_en=0) → result_o = 0x20000, q_o = 0x0200. Then 0x0100 × 0x0080 (acc_en=1) → result_o = 0x28000, q_o = 0x0280.
- Control robustness:
  - start_i pulsed mid-RUN → ignored, single done_o.
  - rst_n low at RUN cycle 4 → all outputs 0, busy_o = 0, no done_o; the next op completes normally.
- clr_i with start_i (acc_en=1, 2 × 3 after prior acc = 100) → result_o = 6. clr_i while busy → no effect.
- Repeat all for BPC ∈ {1, 4}: identical results with latency 16 / 4 cycles.

Source files
------------

// File: rtl/mul_mac_pkg.sv
// mul_mac_pkg: shared types and helpers for the sequential multiply-accumulate datapath
package mul_mac_pkg;

    typedef enum logic {IDLE, RUN} state_t;

    function automatic int acc_width(input int width, input int guard);
        return 2 * width + guard;
    endfunction

    function automatic logic [63:0] round_bias(input int frac);
        return 64'd1 << (frac - 1);
    endfunction

    // Clamp value; the caller keeps the low width bits
    function automatic logic [63:0] q_bound(input logic sgn, input logic neg, input int width);
        logic [63:0] m;
        m = (64'd1 << width) - 64'd1;
        return !sgn ? m : neg ? ~(m >> 1) : m >> 1;
    endfunction

endpackage

// File: rtl/mul_q_round.sv
// mul_q_round: round-half-up and saturate an accumulator down to a WIDTH-bit Q-format value
module mul_q_round
    import mul_mac_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int ACC_W = 36
) (
    input  logic [ACC_W-1:0] acc,
    input  logic             sgn,
    output logic [WIDTH-1:0] q,
    output logic             sat
);

    localparam int TW = ACC_W + 1 - FRAC;

    logic [ACC_W:0] ext;
    logic [TW-1:0]  t;

    always_comb begin
        ext = {sgn & acc[ACC_W-1], acc} + (ACC_W+1)'(round_bias(FRAC));
        // Low TW bits are identical for arithmetic and logical shifts; sgn decides how they are read
        t   = TW'(ext >> FRAC);
        sat = sgn ? !(&t[TW-1:WIDTH-1] || !(|t[TW-1:WIDTH-1])) : |t[TW-1:WIDTH];
        q   = sat ? WIDTH'(q_bound(sgn, t[TW-1], WIDTH)) : t[WIDTH-1:0];
    end

endmodule

// File: rtl/mul_mac_seq.sv
// mul_mac_seq: sequential BPC-bits-per-cycle signed/unsigned multiply-accumulate with Q-format output
module mul_mac_seq
    import mul_mac_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BPC   = 2,
    parameter int FRAC  = 8,
    parameter int GUARD = 4,
    localparam int ACC_W = acc_width(WIDTH, GUARD)
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic             acc_en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [ACC_W-1:0] result_o,
    output logic [WIDTH-1:0] q_o,
    output logic             sat_o,
    output logic             done_o,
    output logic             busy_o
);

    localparam int N  = WIDTH / BPC;
    localparam int CW = $clog2(N + 1);

    state_t           state, state_n;
    logic [CW-1:0]    cnt;
    logic             mode, acc_en, sign, last_mode, accept, last;
    logic [WIDTH-1:0] ma, mb;
    logic [2*WIDTH-1:0] pp, term, pp_sum, prod;
    logic [ACC_W-1:0] acc, p_ext;

    always_ff @(posedge clk_i or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_n;

    always_comb begin
        accept  = state == IDLE && start_i;
        last    = state == RUN && cnt == CW'(N - 1);
        state_n = accept ? RUN : last ? IDLE : state;
        term    = ({{WIDTH{1'b0}}, ma} * {{(2*WIDTH-BPC){1'b0}}, mb[BPC-1:0]}) << (BPC * cnt);
        pp_sum  = pp + term;
        prod    = sign ? -pp_sum : pp_sum;
        p_ext   = {{GUARD{mode & prod[2*WIDTH-1]}}, prod};
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            mode      <= 1'b0;
            acc_en    <= 1'b0;
            sign      <= 1'b0;
            last_mode <= 1'b0;
            ma        <= '0;
            mb        <= '0;
            pp        <= '0;
            acc       <= '0;
            done_o    <= 1'b0;
        end else begin
            done_o <= last;
            if (accept) begin
                mode   <= signed_i;
                acc_en <= acc_en_i;
                sign   <= signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                // Negating the most-negative value yields 2^(WIDTH-1) read as unsigned
                ma     <= (signed_i & a_i[WIDTH-1]) ? -a_i : a_i;
                mb     <= (signed_i & b_i[WIDTH-1]) ? -b_i : b_i;
                pp     <= '0;
                cnt    <= '0;
            end else if (state == RUN) begin
                pp  <= pp_sum;
                mb  <= mb >> BPC;
                cnt <= cnt + CW'(1);
            end
            if (state == IDLE && clr_i) begin
                acc       <= '0;
                last_mode <= 1'b0;
            end else if (last) begin
                acc       <= (acc_en ? acc : '0) + p_ext;
                last_mode <= mode;
            end
        end
    end

    assign result_o = acc;
    assign busy_o   = state == RUN;

    mul_q_round #(.WIDTH(WIDTH), .FRAC(FRAC), .ACC_W(ACC_W)) u_round (
        .acc (acc),
        .sgn (last_mode),
        .q   (q_o),
        .sat (sat_o)
    );

endmodule

// File: tb/tb_mul_mac_seq.sv
// tb_mul_mac_seq: directed checks of mul_mac_seq at BPC = 1, 2 and 4 driven in lockstep
module tb_mul_mac_seq;

    logic        clk_i = 1'b0, rst_n = 1'b0;
    logic        start_i = 1'b0, signed_i = 1'b0, acc_en_i = 1'b0, clr_i = 1'b0;
    logic [15:0] a_i = '0, b_i = '0;
    logic [35:0] res [3];
    logic [15:0] q [3];
    logic        sat [3], done [3], busy [3];
    int          n_cmp = 0, n_err = 0;

    always #5 clk_i = ~clk_i;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mul_mac_seq #(.WIDTH(16), .BPC(g == 0 ? 1 : g == 1 ? 2 : 4), .FRAC(8), .GUARD(4)) dut (
            .clk_i    (clk_i),
            .rst_n    (rst_n),
            .start_i  (start_i),
            .signed_i (signed_i),
            .acc_en_i (acc_en_i),
            .clr_i    (clr_i),
            .a_i      (a_i),
            .b_i      (b_i),
            .result_o (res[g]),
            .q_o      (q[g]),
            .sat_o    (sat[g]),
            .done_o   (done[g]),
            .busy_o   (busy[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [35:0] r, input logic [15:0] qe, input logic se);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s.res[%0d]", tag, d), 64'(res[d]), 64'(r));
            chk($sformatf("%s.q[%0d]", tag, d), 64'(q[d]), 64'(qe));
            chk($sformatf("%s.sat[%0d]", tag, d), 64'(sat[d]), 64'(se));
        end
    endtask

    // mid: 0 none, 1 start pulse while busy, 2 clr pulse while busy
    task automatic op(input string tag, input logic s, input logic en, input logic cl,
                      input logic [15:0] a, input logic [15:0] b, input int mid,
                      input logic [35:0] r, input logic [15:0] qe, input logic se);
        int lat [3] = '{-1, -1, -1};
        int dn [3]  = '{0, 0, 0};
        @(negedge clk_i);
        signed_i = s; acc_en_i = en; clr_i = cl; a_i = a; b_i = b; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0; clr_i = 1'b0; a_i = 16'hA5A5; b_i = 16'h5A5A;
        signed_i = ~s; acc_en_i = ~en;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk_i);
            for (int d = 0; d < 3; d++) begin
                if (c == 0) chk($sformatf("%s.busy[%0d]", tag, d), 64'(busy[d]), 64'd1);
                if (done[d]) begin
                    dn[d]++;
                    if (lat[d] < 0) lat[d] = c;
                end
            end
            if (c == 2 && mid == 1) start_i = 1'b1;
            if (c == 2 && mid == 2) clr_i = 1'b1;
            if (c == 3) begin start_i = 1'b0; clr_i = 1'b0; end
        end
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s.lat[%0d]", tag, d), 64'(lat[d]), 64'(16 >> d));
            chk($sformatf("%s.ndone[%0d]", tag, d), 64'(dn[d]), 64'd1);
            chk($sformatf("%s.idle[%0d]", tag, d), 64'(busy[d]), 64'd0);
        end
        chk_out(tag, r, qe, se);
    endtask

    initial begin
        int dn;
        #12;
        chk_out("reset", 36'h0, 16'h0, 1'b0);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset.busy[%0d]", d), 64'(busy[d]), 64'd0);
            chk($sformatf("reset.done[%0d]", d), 64'(done[d]), 64'd0);
        end
        @(negedge clk_i) rst_n = 1'b1;

        op("s3xm5",    1, 0, 0, 16'h0003, 16'hFFFB, 0, 36'hFFFFFFFF1, 16'h0000, 0);
        op("smin2",    1, 0, 0, 16'h8000, 16'h8000, 0, 36'h040000000, 16'h7FFF, 1);
        op("sminx1",   1, 0, 0, 16'h8000, 16'h0001, 0, 36'hFFFFF8000, 16'hFF80, 0);
        op("umax2",    0, 0, 0, 16'hFFFF, 16'hFFFF, 0, 36'h0FFFE0001, 16'hFFFF, 1);

        @(negedge clk_i) clr_i = 1'b1;
        @(negedge clk_i) clr_i = 1'b0;
        chk_out("clr_idle", 36'h0, 16'h0, 1'b0);

        op("acc0",     0, 0, 0, 16'h0100, 16'h0200, 0, 36'h000020000, 16'h0200, 0);
        op("acc1",     0, 1, 0, 16'h0100, 16'h0080, 1, 36'h000028000, 16'h0280, 0);
        op("half_up",  1, 0, 0, 16'h0180, 16'h0001, 0, 36'h000000180, 16'h0002, 0);
        op("pre100",   0, 0, 0, 16'h000A, 16'h000A, 0, 36'h000000064, 16'h0000, 0);
        op("clrstart", 0, 1, 1, 16'h0002, 16'h0003, 0, 36'h000000006, 16'h0000, 0);
        op("clrbusy",  0, 1, 0, 16'h0002, 16'h0003, 2, 36'h00000000C, 16'h0000, 0);

        @(negedge clk_i);
        signed_i = 1'b0; acc_en_i = 1'b1; a_i = 16'h0002; b_i = 16'h0003; start_i = 1'b1;
        @(negedge clk_i) start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_n = 1'b0;
        #1;
        chk_out("abort", 36'h0, 16'h0, 1'b0);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("abort.busy[%0d]", d), 64'(busy[d]), 64'd0);
            chk($sformatf("abort.done[%0d]", d), 64'(done[d]), 64'd0);
        end
        @(negedge clk_i) rst_n = 1'b1;
        dn = 0;
        repeat (20) begin
            @(negedge clk_i);
            for (int d = 0; d < 3; d++) if (done[d]) dn++;
        end
        chk("abort.nodone", 64'(dn), 64'd0);

        op("after_rst", 1, 1, 0, 16'hFF00, 16'h0003, 0, 36'hFFFFFFD00, 16'hFFFD, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
